param_bus: RTL and testbench

//  Parametrised shared-bus interconnect: NUM_M masters, NUM_S memory-mapped slaves, one clock.

---
 rtl/param_bus.sv | 210 +++++++++++++++++++++
 tb/tb_param_bus.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/param_bus.sv
// param_bus: shared-bus interconnect between NUM_M masters and NUM_S
// memory-mapped slaves on a single clock.
//
// Parameters
//   NUM_M      number of masters (2..8)
//   NUM_S      number of slaves (1..16)
//   ADDR_W     address width
//   DATA_W     data width
//   SLV_SHIFT  slave index = address >> SLV_SHIFT
//   ARB_MODE   0 = fixed priority (master 0 highest), 1 = round-robin
//   MAX_HOLD   round-robin only: max consecutive owner cycles while others wait (0 = unlimited)
//
// Ports
//   clk        clock, all state on rising edge
//   reset_n    synchronous active-low reset
//   M_req      per-master request
//   M_wr       per-master write enable
//   M_address  packed master addresses, master i at [i*ADDR_W +: ADDR_W]
//   M_dout     packed master write data, master i at [i*DATA_W +: DATA_W]
//   M_grant    registered one-hot (or zero) grant
//   M_din      registered read data, broadcast to all masters
//   S_sel      one-hot slave select decoded from the owner address
//   S_wr       owner write enable
//   S_address  owner address
//   S_din      owner write data
//   S_dout     packed slave read data, slave s at [s*DATA_W +: DATA_W]
//   bus_err    registered: owner accessed an unmapped slave index last cycle
module param_bus #(
    parameter int NUM_M     = 2,
    parameter int NUM_S     = 3,
    parameter int ADDR_W    = 8,
    parameter int DATA_W    = 32,
    parameter int SLV_SHIFT = 5,
    parameter int ARB_MODE  = 0,
    parameter int MAX_HOLD  = 0
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic [NUM_M-1:0]          M_req,
    input  logic [NUM_M-1:0]          M_wr,
    input  logic [NUM_M*ADDR_W-1:0]   M_address,
    input  logic [NUM_M*DATA_W-1:0]   M_dout,
    output logic [NUM_M-1:0]          M_grant,
    output logic [DATA_W-1:0]         M_din,
    output logic [NUM_S-1:0]          S_sel,
    output logic                      S_wr,
    output logic [ADDR_W-1:0]         S_address,
    output logic [DATA_W-1:0]         S_din,
    input  logic [NUM_S*DATA_W-1:0]   S_dout,
    output logic                      bus_err
);

    localparam int MW     = (NUM_M > 1) ? $clog2(NUM_M) : 1;
    localparam int HOLD_W = 16;
    localparam logic [HOLD_W-1:0] HOLD_LAST = (MAX_HOLD > 0) ? HOLD_W'(MAX_HOLD - 1) : '0;

    typedef enum logic {ARB_IDLE, ARB_OWNED} arb_state_e;

    arb_state_e          state_q, state_d;
    logic [NUM_M-1:0]    grant_q, grant_d;
    logic [MW-1:0]       ptr_q, ptr_d;      // round-robin search start
    logic [HOLD_W-1:0]   hold_q, hold_d;
    logic [DATA_W-1:0]   din_q, din_d;
    logic                err_q, err_d;

    logic [MW-1:0]       own_idx;
    logic [NUM_M-1:0]    others;
    logic [MW-1:0]       win;
    logic                take;
    logic                owned;
    logic [ADDR_W-1:0]   slv_idx;
    logic                mapped;
    logic [DATA_W-1:0]   rd_data;

    // Winner among req. Fixed priority scans from 0; round-robin rotates the
    // request vector so that the scan starts at 'start' and wraps.
    function automatic logic [MW-1:0] pick(input logic [NUM_M-1:0] req,
                                           input logic [MW-1:0]    start);
        logic [2*NUM_M-1:0] rot;
        logic               found;
        int                 r;
        pick  = '0;
        found = 1'b0;
        rot   = (ARB_MODE == 1) ? ({req, req} >> start) : {{NUM_M{1'b0}}, req};
        for (int i = 0; i < NUM_M; i++) begin
            if (!found && rot[i]) begin
                r = (ARB_MODE == 1) ? int'(start) + i : i;
                if (r >= NUM_M) r = r - NUM_M;
                pick  = MW'(r);
                found = 1'b1;
            end
        end
    endfunction

    always_comb begin
        own_idx = '0;
        for (int i = 0; i < NUM_M; i++) begin
            if (grant_q[i]) own_idx = MW'(i);
        end
    end

    assign others = M_req & ~grant_q;

    // Arbiter next state
    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        ptr_d   = ptr_q;
        hold_d  = hold_q;
        win     = '0;
        take    = 1'b0;
        case (state_q)
            ARB_IDLE: begin
                if (|M_req) begin
                    win  = pick(M_req, ptr_q);
                    take = 1'b1;
                end
            end
            ARB_OWNED: begin
                if (M_req[own_idx]) begin
                    // ptr_q already points one past the owner, so this hands the
                    // bus to the next waiting requester after it.
                    if (ARB_MODE == 1 && MAX_HOLD > 0 && hold_q == HOLD_LAST && |others) begin
                        win  = pick(others, ptr_q);
                        take = 1'b1;
                    end else if (hold_q != '1) begin
                        hold_d = hold_q + 1'b1;
                    end
                end else if (|others) begin
                    win  = pick(others, ptr_q);
                    take = 1'b1;
                end else begin
                    state_d = ARB_IDLE;
                    grant_d = '0;
                    hold_d  = '0;
                end
            end
            default: begin
                state_d = ARB_IDLE;
                grant_d = '0;
                hold_d  = '0;
            end
        endcase
        if (take) begin
            state_d = ARB_OWNED;
            hold_d  = '0;
            ptr_d   = (int'(win) == NUM_M - 1) ? '0 : win + 1'b1;
            for (int i = 0; i < NUM_M; i++) begin
                grant_d[i] = (MW'(i) == win);
            end
        end
    end

    // Owner datapath mux
    always_comb begin
        S_address = '0;
        S_din     = '0;
        S_wr      = 1'b0;
        for (int i = 0; i < NUM_M; i++) begin
            if (grant_q[i]) begin
                S_address = M_address[i*ADDR_W +: ADDR_W];
                S_din     = M_dout[i*DATA_W +: DATA_W];
                S_wr      = M_wr[i];
            end
        end
    end

    assign owned   = |grant_q;
    assign slv_idx = S_address >> SLV_SHIFT;
    assign mapped  = owned && (int'(slv_idx) < NUM_S);

    always_comb begin
        S_sel   = '0;
        rd_data = '0;
        for (int s = 0; s < NUM_S; s++) begin
            if (mapped && int'(slv_idx) == s) begin
                S_sel[s] = 1'b1;
                rd_data  = S_dout[s*DATA_W +: DATA_W];
            end
        end
    end

    // Read data is captured at the end of the address cycle; writes and
    // unmapped accesses return zero.
    assign din_d = (mapped && !S_wr) ? rd_data : '0;
    assign err_d = owned && !mapped;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= ARB_IDLE;
            grant_q <= '0;
            ptr_q   <= '0;
            hold_q  <= '0;
            din_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            ptr_q   <= ptr_d;
            hold_q  <= hold_d;
            din_q   <= din_d;
            err_q   <= err_d;
        end
    end

    assign M_grant = grant_q;
    assign M_din   = din_q;
    assign bus_err = err_q;

endmodule

// File: tb/tb_param_bus.sv
// Bench for param_bus: one fixed-priority instance and one round-robin
// instance (MAX_HOLD=2) driven by the same master/slave stimulus.
module tb_param_bus;

    localparam int NM = 3;
    localparam int NS = 3;
    localparam int AW = 8;
    localparam int DW = 32;

    logic              clk = 1'b0;
    logic              reset_n;
    logic [NM-1:0]     M_req;
    logic [NM-1:0]     M_wr;
    logic [NM*AW-1:0]  M_address;
    logic [NM*DW-1:0]  M_dout;
    logic [NS*DW-1:0]  S_dout;

    logic [NM-1:0]     g    [2];
    logic [DW-1:0]     mdin [2];
    logic [NS-1:0]     sel  [2];
    logic              swr  [2];
    logic [AW-1:0]     sadr [2];
    logic [DW-1:0]     sdin [2];
    logic              berr [2];

    int checks = 0;
    int errors = 0;
    logic cmp_en = 1'b0;

    always #5 clk = ~clk;

    param_bus #(.NUM_M(NM), .NUM_S(NS), .ADDR_W(AW), .DATA_W(DW), .SLV_SHIFT(5),
                .ARB_MODE(0), .MAX_HOLD(0)) dut_fp (
        .clk(clk), .reset_n(reset_n), .M_req(M_req), .M_wr(M_wr),
        .M_address(M_address), .M_dout(M_dout), .M_grant(g[0]), .M_din(mdin[0]),
        .S_sel(sel[0]), .S_wr(swr[0]), .S_address(sadr[0]), .S_din(sdin[0]),
        .S_dout(S_dout), .bus_err(berr[0]));

    param_bus #(.NUM_M(NM), .NUM_S(NS), .ADDR_W(AW), .DATA_W(DW), .SLV_SHIFT(5),
                .ARB_MODE(1), .MAX_HOLD(2)) dut_rr (
        .clk(clk), .reset_n(reset_n), .M_req(M_req), .M_wr(M_wr),
        .M_address(M_address), .M_dout(M_dout), .M_grant(g[1]), .M_din(mdin[1]),
        .S_sel(sel[1]), .S_wr(swr[1]), .S_address(sadr[1]), .S_din(sdin[1]),
        .S_dout(S_dout), .bus_err(berr[1]));

    task automatic chk(input string nm, input int k, input logic [63:0] got, input logic [63:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s[%s] got %0h want %0h at %0t", nm, (k == 0) ? "fp" : "rr", got, want, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Owner as an integer (-1 = nobody), round-robin start, hold count.
    int              m_own  [2] = '{-1, -1};
    int              m_ptr  [2] = '{0, 0};
    int              m_hold [2] = '{0, 0};
    logic [DW-1:0]   m_din  [2] = '{32'h0, 32'h0};
    logic            m_err  [2] = '{1'b0, 1'b0};

    function automatic bit has(input logic [NM-1:0] v, input int j);
        return ((v >> j) & 3'b001) != 3'b000;
    endfunction

    function automatic int pick(input int mode, input logic [NM-1:0] req, input int start);
        for (int i = 0; i < NM; i++) begin
            int j;
            j = (mode == 1) ? (start + i) % NM : i;
            if (has(req, j)) return j;
        end
        return -1;
    endfunction

    function automatic int next_owner(input int mode, input int o, input int p, input int h,
                                      input logic [NM-1:0] req);
        int maxh;
        logic [NM-1:0] oth;
        maxh = (mode == 1) ? 2 : 0;
        if (o < 0) return (req == '0) ? -1 : pick(mode, req, p);
        oth = req & ~(3'b001 << o);
        if (has(req, o)) begin
            if (mode == 1 && maxh > 0 && h == maxh - 1 && oth != '0) return pick(1, oth, o + 1);
            return o;
        end
        if (oth == '0) return -1;
        return pick(mode, oth, o + 1);
    endfunction

    function automatic logic [AW-1:0] addr_of(input int m);
        return AW'(M_address >> (m * AW));
    endfunction

    function automatic logic [DW-1:0] wdata_of(input int m);
        return DW'(M_dout >> (m * DW));
    endfunction

    function automatic logic [DW-1:0] slave_of(input int s);
        return DW'(S_dout >> (s * DW));
    endfunction

    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (!reset_n) begin
                m_own[k] = -1; m_ptr[k] = 0; m_hold[k] = 0;
                m_din[k] = '0; m_err[k] = 1'b0;
            end else begin
                int o, idx, nxt;
                o = m_own[k];
                idx = (o >= 0) ? int'(addr_of(o)) / 32 : 0;
                m_din[k] = (o >= 0 && !has(M_wr, o) && idx < NS) ? slave_of(idx) : '0;
                m_err[k] = (o >= 0 && idx >= NS);
                nxt = next_owner(k, o, m_ptr[k], m_hold[k], M_req);
                if (nxt < 0) m_hold[k] = 0;
                else if (nxt != o) begin
                    m_hold[k] = 0;
                    m_ptr[k]  = (nxt + 1) % NM;
                end else m_hold[k] = m_hold[k] + 1;
                m_own[k] = nxt;
            end
        end
    end

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (cmp_en) begin
            for (int k = 0; k < 2; k++) begin
                int o, idx;
                logic [NM-1:0] eg;
                logic [NS-1:0] es;
                o  = m_own[k];
                eg = (o < 0) ? '0 : (3'b001 << o);
                idx = (o >= 0) ? int'(addr_of(o)) / 32 : 0;
                es = (o >= 0 && idx < NS) ? NS'(3'b001 << idx) : '0;
                chk("grant", k, 64'(g[k]), 64'(eg));
                chk("s_sel", k, 64'(sel[k]), 64'(es));
                chk("s_addr", k, 64'(sadr[k]), (o < 0) ? 64'h0 : 64'(addr_of(o)));
                chk("s_din", k, 64'(sdin[k]), (o < 0) ? 64'h0 : 64'(wdata_of(o)));
                chk("s_wr", k, 64'(swr[k]), (o < 0) ? 64'h0 : 64'(has(M_wr, o)));
                chk("m_din", k, 64'(mdin[k]), 64'(m_din[k]));
                chk("bus_err", k, 64'(berr[k]), 64'(m_err[k]));
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
    endtask

    logic [NM-1:0] rr_seq [7] = '{3'b001, 3'b001, 3'b010, 3'b010, 3'b100, 3'b100, 3'b001};

    initial begin
        reset_n   = 1'b0;
        M_req     = 3'b111;
        M_wr      = 3'b000;
        M_address = {8'h45, 8'h05, 8'h21};
        M_dout    = {32'hC2C2_C2C2, 32'hC1C1_C1C1, 32'hC0C0_C0C0};
        S_dout    = {32'h2222_2222, 32'hDEAD_BEEF, 32'h1111_0000};

        // reset held two cycles with every master requesting
        cyc();
        cmp_en = 1'b1;
        cyc();
        for (int k = 0; k < 2; k++) begin
            chk("rst_grant", k, 64'(g[k]), 64'h0);
            chk("rst_mdin", k, 64'(mdin[k]), 64'h0);
            chk("rst_err", k, 64'(berr[k]), 64'h0);
            chk("rst_sel", k, 64'(sel[k]), 64'h0);
        end

        // fixed priority: 110 from idle, M1 keeps the bus, then hand-over
        #1 reset_n = 1'b1; M_req = 3'b000;
        cyc();
        #1 M_req = 3'b110;
        for (int i = 0; i < 5; i++) begin
            cyc();
            chk("fp_hold", 0, 64'(g[0]), 64'(3'b010));
        end
        #1 M_req = 3'b100;
        cyc();
        chk("fp_handover", 0, 64'(g[0]), 64'(3'b100));

        // round-robin, all requesting, hold limit 2
        #1 reset_n = 1'b0; M_req = 3'b111;
        cyc();
        #1 reset_n = 1'b1;
        for (int i = 0; i < 7; i++) begin
            cyc();
            chk("rr_seq", 1, 64'(g[1]), 64'(rr_seq[i]));
        end

        // read of 0x21 by master 0 -> slave 1
        #1 reset_n = 1'b0; M_req = 3'b000;
        cyc();
        #1 reset_n = 1'b1; M_req = 3'b001; M_wr = 3'b000;
        cyc();
        chk("rd_sel", 0, 64'(sel[0]), 64'(3'b010));
        cyc();
        chk("rd_data", 0, 64'(mdin[0]), 64'hDEAD_BEEF);

        // unmapped write to 0xE0
        #1 M_address[7:0] = 8'hE0; M_wr = 3'b001;
        cyc();
        chk("um_sel", 0, 64'(sel[0]), 64'h0);
        chk("um_err", 0, 64'(berr[0]), 64'h1);
        chk("um_mdin", 0, 64'(mdin[0]), 64'h0);
        #1 M_address[7:0] = 8'h05;
        cyc();
        chk("um_err_clr", 0, 64'(berr[0]), 64'h0);

        // master 1 reading, then reset mid-transfer
        #1 M_req = 3'b010; M_wr = 3'b000;
        cyc();
        chk("mr_grant", 0, 64'(g[0]), 64'(3'b010));
        cyc();
        chk("mr_data", 0, 64'(mdin[0]), 64'h1111_0000);
        #1 reset_n = 1'b0;
        cyc();
        for (int k = 0; k < 2; k++) begin
            chk("mr_rst_grant", k, 64'(g[k]), 64'h0);
            chk("mr_rst_mdin", k, 64'(mdin[k]), 64'h0);
        end
        #1 reset_n = 1'b1; M_req = 3'b000;
        cyc();
        cyc();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
